// File: rtl/ps2_key_decoder_if.sv
// PS/2 receiver bundle: raw pins in, decoded key levels and byte strobes out.
// master = decoder side, slave = pin driver / key consumer side.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       key_space;
  logic       key_left;
  logic       key_right;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output key_space,
    output key_left,
    output key_right,
    output rx_byte,
    output rx_valid,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  key_space,
    input  key_left,
    input  key_right,
    input  rx_byte,
    input  rx_valid,
    input  frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 receiver + scan-code decoder driving space/left/right levels.
// Ports: clk, rst_n (async low), bus (master: ps2 pins in, keys/rx_byte/rx_valid/frame_err out).
// Optional PS2_PARITY_CHECK_EN: drop frames with bad odd parity.
module ps2_key_decoder #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TIMEOUT_US = 200
) (
  input logic               clk,
  input logic               rst_n,
  ps2_key_decoder_if.master bus
);

  localparam int TIMEOUT_CYCLES = CLK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic [1:0] clk_s;
  logic [1:0] dat_s;
  logic       clk_d;
  logic       fall;
  logic       din;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par;
  logic       par_ok;
  logic [TW-1:0] gap;
  logic       ext;
  logic       brk;

  logic       k_space;
  logic       k_left;
  logic       k_right;
  logic [7:0] rx_byte_q;
  logic       rx_valid_q;
  logic       frame_err_q;

  assign din = dat_s[1];

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shreg, par};
`else
  // parity is sampled but has no effect on acceptance
  assign par_ok = par | 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_d <= 1'b1;
      fall  <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], bus.ps2_clk};
      dat_s <= {dat_s[0], bus.ps2_data};
      clk_d <= clk_s[1];
      fall  <= clk_d & ~clk_s[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      gap         <= '0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      k_space     <= 1'b0;
      k_left      <= 1'b0;
      k_right     <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (rx_valid_q) begin
        unique case (rx_byte_q)
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          default: begin
            if (rx_byte_q == 8'h29 && !ext)
              k_space <= ~brk;
            if (rx_byte_q == 8'h6B && ext)
              k_left <= ~brk;
            if (rx_byte_q == 8'h74 && ext)
              k_right <= ~brk;
            ext <= 1'b0;
            brk <= 1'b0;
          end
        endcase
      end

      if (fall) begin
        gap <= '0;
        unique case (state)
          IDLE: begin
            if (!din) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (din && par_ok) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= shreg;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        // stalled frame: abandon it and any pending prefix
        if (gap == TW'(TIMEOUT_CYCLES - 1)) begin
          state       <= IDLE;
          gap         <= '0;
          frame_err_q <= 1'b1;
          ext         <= 1'b0;
          brk         <= 1'b0;
        end else begin
          gap <= gap + TW'(1);
        end
      end
    end
  end

  assign bus.key_space = k_space;
  assign bus.key_left  = k_left;
  assign bus.key_right = k_right;
  assign bus.rx_byte   = rx_byte_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: frames in, expected events queued,
// monitor pops on rx_valid/frame_err and checks byte, keys and latency.
module tb_ps2_key_decoder;

  localparam int H = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_key_decoder_if bus();

  ps2_key_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    bit         err;
    logic [7:0] b;
    logic [2:0] keys;
  } exp_t;

  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int last_fall_cyc = 0;
  int last_err_cyc = 0;

  bit       m_ext;
  bit       m_brk;
  bit [2:0] m_keys;

  logic [2:0] keys_now;
  assign keys_now = {bus.key_right, bus.key_left, bus.key_space};

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b);
    if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (b == 8'h29 && !m_ext) m_keys[0] = !m_brk;
      if (b == 8'h6B && m_ext)  m_keys[1] = !m_brk;
      if (b == 8'h74 && m_ext)  m_keys[2] = !m_brk;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_keys = '0;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.frame_err) last_err_cyc = cyc;
        if (bus.rx_valid && bus.frame_err) begin
          checks++;
          errors++;
          $display("FAIL both_strobes: rx_valid=1 frame_err=1 required not both");
        end
        if (bus.rx_valid || bus.frame_err) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: rx_valid=%0b frame_err=%0b none expected",
                     bus.rx_valid, bus.frame_err);
          end else begin
            e = q.pop_front();
            chk("event_kind", 32'(bus.frame_err), 32'(e.err));
            if (!e.err) chk("rx_byte", 32'(bus.rx_byte), 32'(e.b));
            @(negedge clk);
            chk("keys", 32'(keys_now), 32'(e.keys));
            if (!e.err)
              chk("key_latency_le5", 32'((cyc - stop_cyc) <= 5), 32'd1);
          end
        end
      end
    end
  end

  task automatic bit_out(input logic v, input bit is_stop);
    @(negedge clk);
    bus.ps2_data = v;
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    if (is_stop) stop_cyc = cyc;
    repeat (H) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit bad_stop);
    logic p;
    bit   err;
    exp_t e;
    p = ~(^b) ^ bad_par;
    err = bad_stop;
`ifdef PS2_PARITY_CHECK_EN
    err = err | bad_par;
`endif
    if (!err) model_byte(b);
    e.err = err;
    e.b = b;
    e.keys = m_keys;
    q.push_back(e);
    bit_out(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i], 1'b0);
    bit_out(p, 1'b0);
    bit_out(~bad_stop, 1'b1);
    repeat (20) @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d events pending required 0", q.size());
      q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_keys(input string name);
    chk(name, 32'(keys_now), 32'(m_keys));
  endtask

  initial begin
    logic [7:0] pool [8];
    logic [7:0] b;
    exp_t       e;
    pool = '{8'h29, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h12};
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();

    #23;
    chk("reset_keys", 32'(keys_now), 32'd0);
    chk("reset_rx_byte", 32'(bus.rx_byte), 32'h00);
    chk("reset_strobes", 32'({bus.rx_valid, bus.frame_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h29, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h6B, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    drain(200);
    chk_keys("left_right_held");
    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h6B, 0, 0);
    send_frame(8'h6B, 0, 0);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h12, 0, 0);
    send_frame(8'h29, 0, 1);
    drain(200);
    chk_keys("after_plain_and_stop_err");

    // stall mid-frame after four data bits
    e.err = 1'b1;
    e.b = 8'h00;
    m_ext = 1'b0;
    m_brk = 1'b0;
    e.keys = m_keys;
    q.push_back(e);
    bit_out(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b0);
    drain(25000);
    chk("timeout_gap_ok",
        32'((last_err_cyc - last_fall_cyc) >= 19990 &&
            (last_err_cyc - last_fall_cyc) <= 20010), 32'd1);

    send_frame(8'h29, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);
    send_frame(8'h29, 1, 0);
    drain(200);
    chk_keys("after_parity_frame");

    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    drain(200);
    bit_out(1'b0, 1'b0);
    bit_out(1'b1, 1'b0);
    bit_out(1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_keys", 32'(keys_now), 32'd0);
    chk("async_reset_rx_byte", 32'(bus.rx_byte), 32'h00);
    chk("async_reset_strobes", 32'({bus.rx_valid, bus.frame_err}), 32'd0);
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'hE0, 0, 0);
    send_frame(8'h74, 0, 0);
    drain(200);
    chk_keys("right_after_reset");

    for (int n = 0; n < 40; n++) begin
      b = pool[$urandom_range(7, 0)];
      send_frame(b, ($urandom_range(9, 0) == 0),
                 ($urandom_range(9, 0) == 0));
    end
    drain(400);
    chk_keys("random_final_keys");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
